// File: rtl/vrc7_opll_pkg.sv
// Shared types and constants for the VRC7 OPLL register-write scheduler.
package vrc7_opll_pkg;

    // OPLL register address width used by the queued write record.
    localparam int unsigned OPLL_AW = 6;

    // CPU-side port addresses decoded upstream into wr_addr / wr_data strobes.
    localparam logic [15:0] PORT_ADDR = 16'h9010;
    localparam logic [15:0] PORT_DATA = 16'h9030;

    // One queued register write.
    typedef struct packed {
        logic [OPLL_AW-1:0] addr;
        logic [7:0]         dat;
    } opll_wr_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold
    } wr_state_e;

    // Implemented OPLL registers: $00-$07, $10-$15, $20-$25, $30-$35.
    function automatic logic addr_valid(input logic [OPLL_AW-1:0] a);
        if (a[5:3] == 3'b000) begin
            return 1'b1;
        end
        return (a[5:4] != 2'b00) && (a[3:0] <= 4'd5);
    endfunction

endpackage

// File: rtl/sync_fifo_sc.sv
// Single-clock circular FIFO; pushes while full and pops while empty are ignored.
module sync_fifo_sc #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [PtrW:0]    level_q;
    logic             do_push;
    logic             do_pop;

    // Full/empty are judged on the pre-edge level, so a push into a full
    // queue is dropped even when a pop frees a slot on the same edge.
    assign full    = (level_q == (PtrW + 1)'(Depth));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vrc7_opll_wr_sched.sv
// VRC7 OPLL write scheduler: latches the address port, queues {addr, data}
// pairs and issues them to the FM core on free slots with a minimum gap.
// Optional build macro VRC7_OPLL_OVF_CNT_EN adds full-FIFO drop counting.
module vrc7_opll_wr_sched
    import vrc7_opll_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WAIT_CYC   = 6,
    parameter int unsigned AW         = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_addr,
    input  logic                        wr_data,
    input  logic [7:0]                  cpu_data,
    input  logic                        slot_free,
    output logic                        reg_we,
    output logic [AW-1:0]               reg_addr,
    output logic [7:0]                  reg_dat,
    output logic [$clog2(FIFO_DEPTH):0] q_level,
    output logic                        busy
`ifdef VRC7_OPLL_OVF_CNT_EN
    ,
    output logic [7:0]                  ovf_cnt,
    output logic                        ovf_flag
`endif
);

    localparam logic [7:0] HOLD_INIT = 8'(WAIT_CYC - 1);

    logic [AW-1:0] latch_q;
    wr_state_e     state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] reg_addr_q;
    logic [7:0]    reg_dat_q;
    opll_wr_t      push_wr;
    opll_wr_t      head;
    logic          push_req;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    // Push uses the pre-edge latch, so a same-cycle address write only
    // affects later data writes.
    assign push_wr.addr = latch_q;
    assign push_wr.dat  = cpu_data;
    assign push_req     = wr_data && addr_valid(latch_q);

    sync_fifo_sc #(
        .Width ($bits(opll_wr_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .wdata (push_wr),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    // Address latch; upper cpu_data bits are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '0;
        end else if (wr_addr) begin
            latch_q <= cpu_data[AW-1:0];
        end
    end

    // Issue FSM next-state and pop decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && slot_free) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StHold;
                cnt_d   = HOLD_INIT;
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, hold counter and the registered write presented to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            reg_addr_q <= '0;
            reg_dat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pop) begin
                reg_addr_q <= head.addr;
                reg_dat_q  <= head.dat;
            end
        end
    end

    assign reg_we   = (state_q == StIssue);
    assign reg_addr = reg_addr_q;
    assign reg_dat  = reg_dat_q;
    assign busy     = (q_level != '0) || (state_q != StIdle);

`ifdef VRC7_OPLL_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;
    logic       ovf_flag_q;

    // Count valid-address pushes lost to a full queue; saturate at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_q  <= 8'd0;
            ovf_flag_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            ovf_flag_q <= 1'b1;
            if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
        end
    end

    assign ovf_cnt  = ovf_cnt_q;
    assign ovf_flag = ovf_flag_q;
`endif

endmodule

// File: tb/tb_vrc7_opll_wr_sched.sv
// Directed, table-driven bench for vrc7_opll_wr_sched (defaults: depth 8, gap 6).
module tb_vrc7_opll_wr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_addr = 1'b0;
    logic       wr_data = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       slot_free = 1'b0;
    logic       reg_we;
    logic [5:0] reg_addr;
    logic [7:0] reg_dat;
    logic [3:0] q_level;
    logic       busy;
`ifdef VRC7_OPLL_OVF_CNT_EN
    logic [7:0] ovf_cnt;
    logic       ovf_flag;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vrc7_opll_wr_sched #(
        .FIFO_DEPTH (8),
        .WAIT_CYC   (6),
        .AW         (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_data  (cpu_data),
        .slot_free (slot_free),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_dat   (reg_dat),
        .q_level   (q_level),
        .busy      (busy)
`ifdef VRC7_OPLL_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt),
        .ovf_flag  (ovf_flag)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       ok;
        logic [5:0] ea;
    } vec_t;

    vec_t vt[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        wr_addr = 1'b0;
        wr_data = 1'b0;
        slot_free = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr_a(input logic [7:0] d);
        wr_addr = 1'b1;
        cpu_data = d;
        tick();
        wr_addr = 1'b0;
    endtask

    task automatic wr_d(input logic [7:0] d);
        wr_data = 1'b1;
        cpu_data = d;
        tick();
        wr_data = 1'b0;
    endtask

    task automatic wait_we(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (reg_we) seen = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         seen;
        int         np;
        int         nwe;
        int         pos[8];
        logic [7:0] pdat[8];

        vt[0]  = '{8'h00, 8'h11, 1'b1, 6'h00};
        vt[1]  = '{8'h07, 8'h22, 1'b1, 6'h07};
        vt[2]  = '{8'h08, 8'h33, 1'b0, 6'h00};
        vt[3]  = '{8'h0F, 8'h34, 1'b0, 6'h00};
        vt[4]  = '{8'h10, 8'h44, 1'b1, 6'h10};
        vt[5]  = '{8'h15, 8'h55, 1'b1, 6'h15};
        vt[6]  = '{8'h16, 8'h56, 1'b0, 6'h00};
        vt[7]  = '{8'h20, 8'h66, 1'b1, 6'h20};
        vt[8]  = '{8'h25, 8'h77, 1'b1, 6'h25};
        vt[9]  = '{8'h26, 8'h78, 1'b0, 6'h00};
        vt[10] = '{8'h35, 8'h88, 1'b1, 6'h35};
        vt[11] = '{8'h36, 8'h89, 1'b0, 6'h00};
        vt[12] = '{8'hC5, 8'h99, 1'b1, 6'h05};  // upper bits dropped -> $05
        vt[13] = '{8'hF8, 8'h9A, 1'b0, 6'h00};  // -> $38, invalid

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_reg_we", reg_we, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_dat", reg_dat, 0);
        chk("rst_q_level", q_level, 0);
        chk("rst_busy", busy, 0);

        // Address decode table
        for (int i = 0; i < 14; i++) begin
            do_reset();
            wr_a(vt[i].a);
            wr_d(vt[i].d);
            chk($sformatf("vec%0d_level", i), q_level, {3'b0, vt[i].ok});
            if (vt[i].ok) begin
                slot_free = 1'b1;
                wait_we(5, seen);
                chk($sformatf("vec%0d_we", i), seen, 1);
                chk($sformatf("vec%0d_addr", i), reg_addr, vt[i].ea);
                chk($sformatf("vec%0d_dat", i), reg_dat, vt[i].d);
            end
        end

        // Basic write: data in cycle 1, reg_we in cycle 3, busy low after HOLD
        do_reset();
        slot_free = 1'b1;
        wr_a(8'h10);
        wr_d(8'hA5);
        chk("basic_we_early", reg_we, 0);
        tick();
        chk("basic_we", reg_we, 1);
        chk("basic_addr", reg_addr, 8'h10);
        chk("basic_dat", reg_dat, 8'hA5);
        for (int i = 0; i < 6; i++) tick();
        chk("basic_busy_hold", busy, 1);
        tick();
        chk("basic_busy_idle", busy, 0);
        chk("basic_we_low", reg_we, 0);
        chk("basic_dat_held", reg_dat, 8'hA5);

        // Back-to-back writes: pulses 8 cycles apart
        do_reset();
        slot_free = 1'b1;
        wr_a(8'h20);
        np = 0;
        for (int i = 0; i < 40; i++) begin
            wr_data = (i < 3);
            cpu_data = 8'(i + 1);
            tick();
            if (reg_we && np < 8) begin
                pos[np] = i;
                pdat[np] = reg_dat;
                np++;
            end
        end
        wr_data = 1'b0;
        chk("b2b_count", np, 3);
        for (int k = 0; k < 3 && k < np; k++) begin
            chk($sformatf("b2b_pos%0d", k), pos[k], 1 + 8 * k);
            chk($sformatf("b2b_dat%0d", k), pdat[k], k + 1);
        end

        // Slot stall
        do_reset();
        wr_a(8'h30);
        wr_d(8'h01);
        wr_d(8'h02);
        nwe = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (reg_we) nwe++;
        end
        chk("stall_no_we", nwe, 0);
        chk("stall_level", q_level, 2);
        slot_free = 1'b1;
        tick();
        chk("stall_release_we", reg_we, 1);
        chk("stall_release_dat", reg_dat, 8'h01);

        // Invalid address and overflow
        do_reset();
        wr_a(8'h08);
        wr_d(8'h5A);
        chk("invalid_level", q_level, 0);
`ifdef VRC7_OPLL_OVF_CNT_EN
        chk("invalid_ovf_cnt", ovf_cnt, 0);
`endif
        wr_a(8'h30);
        for (int i = 0; i < 10; i++) wr_d(8'(8'h40 + i));
        chk("ovf_level", q_level, 8);
        chk("ovf_busy", busy, 1);
`ifdef VRC7_OPLL_OVF_CNT_EN
        chk("ovf_cnt", ovf_cnt, 2);
        chk("ovf_flag", ovf_flag, 1);
        wr_a(8'h08);
        wr_d(8'h00);
        chk("ovf_cnt_invalid_full", ovf_cnt, 2);
`endif
        slot_free = 1'b1;
        tick();
        chk("ovf_head_dat", reg_dat, 8'h40);

        // Same-cycle address and data: push uses old latch
        do_reset();
        wr_a(8'h05);
        wr_addr = 1'b1;
        wr_data = 1'b1;
        cpu_data = 8'h33;
        tick();
        wr_addr = 1'b0;
        wr_data = 1'b0;
        wr_d(8'h44);  // latch now $33, which lies in $30-$35
        chk("same_level", q_level, 2);
        slot_free = 1'b1;
        wait_we(5, seen);
        chk("same_we0", seen, 1);
        chk("same_addr0", reg_addr, 8'h05);
        chk("same_dat0", reg_dat, 8'h33);
        wait_we(12, seen);
        chk("same_we1", seen, 1);
        chk("same_addr1", reg_addr, 8'h33);
        chk("same_dat1", reg_dat, 8'h44);

        // Reset mid-operation
        do_reset();
        slot_free = 1'b1;
        wr_a(8'h10);
        for (int i = 0; i < 5; i++) wr_d(8'(8'h60 + i));
        chk("mid_pre_level", q_level, 4);
        chk("mid_pre_busy", busy, 1);
        chk("mid_pre_we", reg_we, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_level", q_level, 0);
        chk("mid_we", reg_we, 0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", reg_addr, 0);
        nwe = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (reg_we) nwe++;
        end
        chk("mid_no_we", nwe, 0);
        slot_free = 1'b0;
        wr_d(8'h77);  // latch cleared to $00, a valid address
        chk("mid_latch_level", q_level, 1);
        slot_free = 1'b1;
        wait_we(5, seen);
        chk("mid_latch_we", seen, 1);
        chk("mid_latch_addr", reg_addr, 0);
        chk("mid_latch_dat", reg_dat, 8'h77);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
